// File: rtl/pooling_pkg.sv
// Shared types for the pooling window feeder: pixel/window types,
// window slot indices and the feeder FSM encoding.
package pooling_pkg;

    localparam int DATA_W = 8;
    localparam int K      = 2;
    localparam int S      = 2;
    localparam int WIN_SZ = K * S;

    localparam int TL = 3;
    localparam int TR = 2;
    localparam int BL = 1;
    localparam int BR = 0;

    typedef logic [DATA_W-1:0] pix_t;
    typedef pix_t [WIN_SZ-1:0] window_t;

    typedef enum logic [1:0] {
        FILL,
        ISSUE,
        HOLD
    } feeder_state_t;

endpackage

// File: rtl/pool_line_buffer.sv
// One image row of pixels in flops; single write port and a read port
// returning the adjacent pair (col-1, col) for the top half of a window.
module pool_line_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rd_lo_o,
    output logic [DW-1:0] rd_hi_o
);

    logic [DEPTH-1:0][DW-1:0] mem_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd_hi_o = mem_q[raddr_i];
    assign rd_lo_o = mem_q[raddr_i - AW'(1)];

endmodule

// File: rtl/pooling_window_feeder.sv
// Turns a row-major pixel stream into batches of 2x2 windows for the
// pooling layer, issuing a start_pool pulse per batch and holding it.
module pooling_window_feeder
    import pooling_pkg::*;
#(
    parameter int data_width    = DATA_W,
    parameter int pooling_units = 4,
    parameter int IMG_W         = 4,
    parameter int IMG_H         = 4,
    parameter int POOL_LAT      = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic pix_valid,
    input  logic [data_width-1:0] pix_in,
    output logic pix_ready,
    input  logic pool_mode,
    output logic [pooling_units-1:0][WIN_SZ-1:0][data_width-1:0] pooling_in,
    output logic start_pool,
    output logic ctrl_pool,
    output logic frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = (pooling_units > 1) ? $clog2(pooling_units) : 1;
    localparam int HW = (POOL_LAT > 0) ? $clog2(POOL_LAT + 1) : 1;

    typedef logic [data_width-1:0] px_t;
    typedef px_t [WIN_SZ-1:0] win_t;
    typedef win_t [pooling_units-1:0] batch_t;

    feeder_state_t state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [HW-1:0] hold_q, hold_d;
    px_t           pend_q, pend_d;
    batch_t        stage_q, stage_d;
    batch_t        pin_q, pin_d;
    logic          fd_q, fd_d;
    logic          ctrl_q, ctrl_d;
    logic          rdy_q;
    logic          xfer, go_issue, frame_last;
    px_t           lb_tl, lb_tr;
    win_t          win;

    assign xfer = pix_valid && rdy_q;
    assign frame_last = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));

    pool_line_buffer #(
        .DW    (data_width),
        .DEPTH (IMG_W)
    ) u_lb (
        .clk     (clk),
        .nrst    (nrst),
        .we_i    (xfer && !row_q[0]),
        .waddr_i (col_q),
        .wdata_i (pix_in),
        .raddr_i (col_q),
        .rd_lo_o (lb_tl),
        .rd_hi_o (lb_tr)
    );

    always_comb begin
        win     = '0;
        win[TL] = lb_tl;
        win[TR] = lb_tr;
        win[BL] = pend_q;
        win[BR] = pix_in;
    end

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        lane_d   = lane_q;
        pend_d   = pend_q;
        stage_d  = stage_q;
        pin_d    = pin_q;
        fd_d     = fd_q;
        ctrl_d   = ctrl_q;
        go_issue = 1'b0;
        if (xfer) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (row_q == '0 && col_q == '0) ctrl_d = pool_mode;
            if (row_q[0] && !col_q[0]) pend_d = pix_in;
            if (row_q[0] && col_q[0]) begin
                // First window of a batch occupies the highest lane
                stage_d[LW'(pooling_units - 1) - lane_q] = win;
                if (lane_q == LW'(pooling_units - 1) || frame_last) begin
                    go_issue = 1'b1;
                    pin_d    = stage_d;
                    fd_d     = frame_last;
                    stage_d  = '0;
                    lane_d   = '0;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        unique case (state_q)
            FILL:  if (go_issue) state_d = ISSUE;
            ISSUE: state_d = (POOL_LAT == 0) ? FILL : HOLD;
            HOLD: begin
                hold_d = hold_q + HW'(1);
                if (hold_q == HW'(POOL_LAT - 1)) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= FILL;
            hold_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rdy_q   <= (state_d == FILL);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            col_q   <= '0;
            row_q   <= '0;
            lane_q  <= '0;
            pend_q  <= '0;
            stage_q <= '0;
            pin_q   <= '0;
            fd_q    <= 1'b0;
            ctrl_q  <= 1'b1;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            lane_q  <= lane_d;
            pend_q  <= pend_d;
            stage_q <= stage_d;
            pin_q   <= pin_d;
            fd_q    <= fd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        start_pool = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ISSUE: begin
                start_pool = 1'b1;
                frame_done = fd_q;
            end
            default: ;
        endcase
    end

    assign pix_ready  = rdy_q;
    assign pooling_in = pin_q;
    assign ctrl_pool  = ctrl_q;

endmodule
